bin_to_bcd: RTL and testbench



---
 rtl/bin_to_bcd.sv | 164 ++++++++++++++++
 tb/tb_bin_to_bcd.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock.
// Define BIN2BCD_SIGNED_EN to treat `bin` as two's complement and add the `neg` output.
module bin_to_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  neg
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // Decimal digits needed to show the largest WIDTH-bit unsigned value.
  function automatic int digits_needed(input int w);
    longint unsigned v;
    int n;
    v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    n = 1;
    v = v / 10;
    while (v != 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  if (DIGITS < digits_needed(WIDTH)) begin : g_digits_check
    $error("bin_to_bcd: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BW-1:0]    bcd_q, bcd_d;

  logic [WIDTH-1:0] load_val;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    scratch_nx;

`ifdef BIN2BCD_SIGNED_EN
  logic             neg_pend_q, neg_pend_d;
  logic             neg_q, neg_d;
  logic [WIDTH:0]   bin_ext;
  logic [WIDTH:0]   mag_ext;

  // Negating in WIDTH+1 bits lets the most negative input yield its true magnitude.
  always_comb begin
    bin_ext  = {bin[WIDTH-1], bin};
    mag_ext  = bin[WIDTH-1] ? (~bin_ext + {{WIDTH{1'b0}}, 1'b1}) : bin_ext;
    load_val = mag_ext[WIDTH-1:0];
  end
`else
  always_comb load_val = bin;
`endif

  // Add 3 to every digit >= 5, independently per digit, before the shift.
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
    end
    scratch_nx = {adj[BW-2:0], shift_q[WIDTH-1]};
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
`ifdef BIN2BCD_SIGNED_EN
    neg_pend_d = neg_pend_q;
    neg_d      = neg_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SHIFT;
          shift_d   = load_val;
          scratch_d = '0;
          cnt_d     = '0;
`ifdef BIN2BCD_SIGNED_EN
          neg_pend_d = bin[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = scratch_nx;
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          bcd_d   = scratch_nx;
`ifdef BIN2BCD_SIGNED_EN
          neg_d   = neg_pend_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
`ifdef BIN2BCD_SIGNED_EN
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
`ifdef BIN2BCD_SIGNED_EN
      neg_pend_q <= neg_pend_d;
      neg_q      <= neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BIN2BCD_SIGNED_EN
  assign neg  = neg_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd (WIDTH=8, DIGITS=3); results checked by a done-driven scoreboard.
module tb_bin_to_bcd;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  typedef struct packed {
    logic        neg;
    logic [11:0] bcd;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  bin;
  logic              busy;
  logic              done;
  logic [4*DIGITS-1:0] bcd;
`ifdef BIN2BCD_SIGNED_EN
  logic              neg;
`endif

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef BIN2BCD_SIGNED_EN
    ,
    .neg   (neg)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bcd_of(input int n);
    logic [3:0] h, t, u;
    h = 4'(n / 100 % 10);
    t = 4'(n / 10 % 10);
    u = 4'(n % 10);
    return {h, t, u};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("bcd_result", {20'd0, bcd}, {20'd0, e.bcd});
`ifdef BIN2BCD_SIGNED_EN
        check("neg_result", {31'd0, neg}, {31'd0, e.neg});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after an accept edge; lat counts edges including the accept edge.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (done !== 1'b1 && lat < 30) begin
      if (busy === 1'b1) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic convert(input logic [WIDTH-1:0] v, input logic [11:0] e, input logic en);
    int lat, busy_n;
    exp_q.push_back('{neg: en, bcd: e});
    bin = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin = WIDTH'($urandom);
    wait_done(lat, busy_n);
    check("latency", lat, 32'd9);
    check("busy_cycles", busy_n, 32'd8);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("bcd_hold", {20'd0, bcd}, {20'd0, e});
  endtask

  initial begin
    int lat, busy_n, d0;
    rst = 1'b1;
    start = 1'b0;
    bin = '0;
    repeat (3) tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd", {20'd0, bcd}, 32'd0);
`ifdef BIN2BCD_SIGNED_EN
    check("reset_neg", {31'd0, neg}, 32'd0);
`endif
    rst = 1'b0;
    tick();

`ifdef BIN2BCD_SIGNED_EN
    convert(8'h00, 12'h000, 1'b0);
    convert(8'h80, 12'h128, 1'b1);
    convert(8'hFF, 12'h001, 1'b1);
    convert(8'h7F, 12'h127, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] r;
      int sv;
      r = WIDTH'($urandom);
      sv = int'($signed(r));
      convert(r, bcd_of(sv < 0 ? -sv : sv), r[WIDTH-1]);
    end
`else
    convert(8'd0,   12'h000, 1'b0);
    convert(8'd255, 12'h255, 1'b0);
    convert(8'd99,  12'h099, 1'b0);
    convert(8'd100, 12'h100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] r;
      r = WIDTH'($urandom);
      convert(r, bcd_of(int'(r)), 1'b0);
    end
`endif

    // Requests while busy are dropped.
    d0 = done_cnt;
    exp_q.push_back('{neg: 1'b0, bcd: 12'h042});
    bin = 8'd42;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bin = 8'd17;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check("busy_start_done_count", done_cnt - d0, 32'd1);
    check("busy_start_bcd", {20'd0, bcd}, 32'h042);

    // Start held high: accepted again in the DONE cycle.
    exp_q.push_back('{neg: 1'b0, bcd: 12'h042});
    exp_q.push_back('{neg: 1'b0, bcd: 12'h017});
    bin = 8'd42;
    start = 1'b1;
    tick();
    bin = 8'd17;
    wait_done(lat, busy_n);
    check("b2b_first_latency", lat, 32'd9);
    tick();
    start = 1'b0;
    bin = 8'd0;
    wait_done(lat, busy_n);
    check("b2b_second_latency", lat, 32'd9);
    check("b2b_second_busy", busy_n, 32'd8);
    tick();

    // Reset mid-conversion abandons it.
    d0 = done_cnt;
    bin = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_bcd", {20'd0, bcd}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    repeat (14) tick();
    check("midrst_no_done", done_cnt - d0, 32'd0);
    convert(8'd123, 12'h123, 1'b0);

    repeat (2) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
